// File: rtl/mem_access_ctrl.sv
// Burst memory access sequencer for the two on-chip BRAM blocks.
// Accepts one command at a time and walks the address range one word per
// cycle, driving the {block, write} enable code, address and write data.
// Read words are realigned to the BRAM read latency by a valid-bit shift
// register and returned with the block selected at command time.
module mem_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_block,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] block1_dout,
    input  logic [DATA_W-1:0] block2_dout,
    output logic [1:0]        memoryena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [RD_LAT-1:0] PIPE_ZERO = {RD_LAT{1'b0}};

    // Registered state
    state_t              state_r;
    logic                blk_r;       // block latched at command time
    logic [LEN_W-1:0]    cnt_r;       // words remaining after the current one
    logic [ADDR_W-1:0]   addr_r;      // next address to present
    logic                issue_r;     // a read address is on the bus this cycle
    logic [RD_LAT-1:0]   pipe_r;      // read-valid alignment shift register
    logic [1:0]          memoryena_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_din_r;
    logic                rd_valid_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                done_r;
    logic                cmd_ready_r;
    logic                wr_ready_r;
    logic                busy_r;

    // Next-state values
    state_t              state_nxt_s;
    logic                blk_nxt_s;
    logic [LEN_W-1:0]    cnt_nxt_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic                issue_nxt_s;
    logic [RD_LAT-1:0]   pipe_nxt_s;
    logic [RD_LAT-1:0]   pipe_shift_s;
    logic [1:0]          memoryena_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_nxt_s;
    logic [DATA_W-1:0]   mem_din_nxt_s;
    logic                rd_valid_nxt_s;
    logic [DATA_W-1:0]   rd_data_nxt_s;
    logic                done_nxt_s;
    logic                wr_accept_s;

    // A read issue on the bus this cycle enters the shift register; after
    // RD_LAT stages its bit lines up with the BRAM output of that address.
    generate
        if (RD_LAT == 1) begin : g_pipe_one
            assign pipe_shift_s = issue_r;
        end else begin : g_pipe_many
            assign pipe_shift_s = {pipe_r[RD_LAT-2:0], issue_r};
        end
    endgenerate

    assign wr_accept_s = wr_valid && wr_ready_r;

    // Next-state, address/count and output-register computation.
    always_comb begin
        state_nxt_s     = state_r;
        blk_nxt_s       = blk_r;
        cnt_nxt_s       = cnt_r;
        addr_nxt_s      = addr_r;
        issue_nxt_s     = 1'b0;
        pipe_nxt_s      = pipe_shift_s;
        memoryena_nxt_s = 2'b00;
        mem_addr_nxt_s  = mem_addr_r;
        mem_din_nxt_s   = mem_din_r;
        done_nxt_s      = 1'b0;
        rd_valid_nxt_s  = pipe_r[RD_LAT-1];

        // Capture uses the latched block so a later command cannot steer
        // an in-flight word to the wrong source.
        if (pipe_r[RD_LAT-1]) begin
            rd_data_nxt_s = blk_r ? block2_dout : block1_dout;
        end else begin
            rd_data_nxt_s = rd_data_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    blk_nxt_s       = cmd_block;
                    cnt_nxt_s       = cmd_len;
                    memoryena_nxt_s = {cmd_block, 1'b0};
                    if (cmd_write) begin
                        addr_nxt_s  = cmd_addr;
                        state_nxt_s = ST_WRITE;
                    end else begin
                        // First read address goes out on the acceptance edge.
                        mem_addr_nxt_s = cmd_addr;
                        addr_nxt_s     = cmd_addr + ADDR_ONE;
                        issue_nxt_s    = 1'b1;
                        if (cmd_len == LEN_ZERO) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            state_nxt_s = ST_READ;
                        end
                    end
                end else begin
                    memoryena_nxt_s = 2'b00;
                end
            end

            ST_WRITE: begin
                if (wr_accept_s) begin
                    memoryena_nxt_s = {blk_r, 1'b1};
                    mem_addr_nxt_s  = addr_r;
                    mem_din_nxt_s   = wr_data;
                    addr_nxt_s      = addr_r + ADDR_ONE;
                    if (cnt_r == LEN_ZERO) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - LEN_ONE;
                    end
                end else begin
                    memoryena_nxt_s = {blk_r, 1'b0};
                end
            end

            ST_READ: begin
                memoryena_nxt_s = {blk_r, 1'b0};
                mem_addr_nxt_s  = addr_r;
                addr_nxt_s      = addr_r + ADDR_ONE;
                issue_nxt_s     = 1'b1;
                cnt_nxt_s       = cnt_r - LEN_ONE;
                if (cnt_r == LEN_ONE) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end

            ST_DRAIN: begin
                memoryena_nxt_s = 2'b00;
                if (!issue_r && (pipe_r == PIPE_ZERO)) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, read pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_r       <= 1'b0;
            cnt_r       <= LEN_ZERO;
            addr_r      <= ADDR_ZERO;
            issue_r     <= 1'b0;
            pipe_r      <= PIPE_ZERO;
            memoryena_r <= 2'b00;
            mem_addr_r  <= ADDR_ZERO;
            mem_din_r   <= DATA_ZERO;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= DATA_ZERO;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            wr_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            blk_r       <= blk_nxt_s;
            cnt_r       <= cnt_nxt_s;
            addr_r      <= addr_nxt_s;
            issue_r     <= issue_nxt_s;
            pipe_r      <= pipe_nxt_s;
            memoryena_r <= memoryena_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_din_r   <= mem_din_nxt_s;
            rd_valid_r  <= rd_valid_nxt_s;
            rd_data_r   <= rd_data_nxt_s;
            done_r      <= done_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            wr_ready_r  <= (state_nxt_s == ST_WRITE);
            busy_r      <= (state_nxt_s != ST_IDLE) || issue_nxt_s ||
                           (pipe_nxt_s != PIPE_ZERO);
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wr_ready  = wr_ready_r;
    assign memoryena = memoryena_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a two-block BRAM model of
// read latency 2. Stimulus pushes hand-computed expectations (with the
// cycle they must appear in); a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write, cmd_block;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] block1_dout, block2_dout;
    logic [1:0]        memoryena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              busy, done;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_block(cmd_block), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .block1_dout(block1_dout), .block2_dout(block2_dout),
        .memoryena(memoryena), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model (latency 2, unwritten words = tag|addr)
    logic [DATA_W-1:0] mem1 [1024];
    logic [DATA_W-1:0] mem2 [1024];
    bit                wr1  [1024];
    bit                wr2  [1024];
    logic [DATA_W-1:0] b1_s1, b1_s2, b2_s1, b2_s2;
    logic              force2 = 1'b0;

    function automatic logic [DATA_W-1:0] rd1(input logic [ADDR_W-1:0] a);
        return wr1[a] ? mem1[a] : (32'h1000_0000 | {22'd0, a});
    endfunction
    function automatic logic [DATA_W-1:0] rd2(input logic [ADDR_W-1:0] a);
        return wr2[a] ? mem2[a] : (32'h2000_0000 | {22'd0, a});
    endfunction

    always @(posedge clk) begin
        if (memoryena[0]) begin
            if (memoryena[1]) begin mem2[mem_addr] <= mem_din; wr2[mem_addr] <= 1'b1; end
            else              begin mem1[mem_addr] <= mem_din; wr1[mem_addr] <= 1'b1; end
        end
        b1_s1 <= rd1(mem_addr); b1_s2 <= b1_s1;
        b2_s1 <= rd2(mem_addr); b2_s2 <= b2_s1;
    end
    assign block1_dout = b1_s2;
    assign block2_dout = force2 ? 32'h0000_DEAD : b2_s2;

    // ---------------- scoreboard
    typedef struct {
        int                cyc;
        logic [1:0]        ena;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t wr_q[$];
    exp_t iss_q[$];
    exp_t rd_q[$];
    int   done_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic [DATA_W-1:0] xd [8];

    // Monitor: compare every DUT event against the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (mon_en) begin
            if (memoryena[0]) begin
                n_vec++;
                if (wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: cyc %0d ena=%b addr=%h data=%h, required no write", cyc, memoryena, mem_addr, mem_din);
                end else begin
                    e = wr_q.pop_front();
                    if (e.cyc != cyc || memoryena !== e.ena || mem_addr !== e.addr || mem_din !== e.data) begin
                        n_err++;
                        $display("FAIL wr: cyc %0d ena=%b addr=%h data=%h, required cyc %0d ena=%b addr=%h data=%h",
                                 cyc, memoryena, mem_addr, mem_din, e.cyc, e.ena, e.addr, e.data);
                    end
                end
            end
            if (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
                e = iss_q.pop_front();
                n_vec++;
                if (e.cyc != cyc || memoryena !== e.ena || mem_addr !== e.addr) begin
                    n_err++;
                    $display("FAIL rd_issue: cyc %0d ena=%b addr=%h, required cyc %0d ena=%b addr=%h",
                             cyc, memoryena, mem_addr, e.cyc, e.ena, e.addr);
                end
            end
            if (rd_valid) begin
                n_vec++;
                if (rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: cyc %0d rd_data=%h, required no rd_valid", cyc, rd_data);
                end else begin
                    e = rd_q.pop_front();
                    if (e.cyc != cyc || rd_data !== e.data) begin
                        n_err++;
                        $display("FAIL rd_data: cyc %0d data=%h, required cyc %0d data=%h", cyc, rd_data, e.cyc, e.data);
                    end
                end
            end
            if (done) begin
                n_vec++;
                if (done_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: cyc %0d, required no done", cyc);
                end else begin
                    dc = done_q.pop_front();
                    if (dc != cyc) begin
                        n_err++;
                        $display("FAIL done_cycle: cyc %0d, required cyc %0d", cyc, dc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, got, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        logic [80:0] got;
        logic [80:0] want;
        got  = {cmd_ready, wr_ready, memoryena, mem_addr, mem_din, rd_valid, rd_data, busy, done};
        want = {1'b1, 1'b0, 2'b00, 10'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: outputs %h, required %h", tag, got, want);
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((wr_q.size() + iss_q.size() + rd_q.size() + done_q.size()) != 0 && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if ((wr_q.size() + iss_q.size() + rd_q.size() + done_q.size()) != 0) begin
            n_err++;
            $display("FAIL %s_timeout: pending wr=%0d iss=%0d rd=%0d done=%0d, required all 0",
                     tag, wr_q.size(), iss_q.size(), rd_q.size(), done_q.size());
            wr_q.delete(); iss_q.delete(); rd_q.delete(); done_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic issue_cmd(input logic wr, input logic blk, input logic [ADDR_W-1:0] a, input int n);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_block = blk;
        cmd_addr = a; cmd_len = LEN_W'(n - 1);
    endtask

    // Write burst; pat bit k is wr_valid in the k-th cycle of WRITE (1 beyond patlen).
    task automatic do_write(input logic blk, input logic [ADDR_W-1:0] addr, input int n,
                            input logic [DATA_W-1:0] base, input logic [15:0] pat, input int patlen);
        int acc;
        int k;
        logic [ADDR_W-1:0] a;
        logic v;
        issue_cmd(1'b1, blk, addr, n);
        tick();
        cmd_valid = 1'b0;
        acc = 0; k = 0; a = addr;
        while (acc < n && k < 64) begin
            v = (k < patlen) ? pat[k] : 1'b1;
            wr_valid = v;
            wr_data  = base + DATA_W'(acc);
            if (v) begin
                wr_q.push_back('{cyc + 1, {blk, 1'b1}, a, base + DATA_W'(acc)});
                if (acc == n - 1) done_q.push_back(cyc + 1);
                a   = a + 10'd1;
                acc = acc + 1;
            end
            k++;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    // Read burst of n words with expected data in xd; poke drives ignored inputs.
    task automatic do_read(input logic blk, input logic [ADDR_W-1:0] addr, input int n, input bit poke);
        int t;
        logic [ADDR_W-1:0] a;
        t = cyc;
        a = addr;
        for (int i = 0; i < n; i++) begin
            iss_q.push_back('{t + 1 + i, {blk, 1'b0}, a, 32'h0});
            rd_q.push_back('{t + 2 + i + RD_LAT, 2'b00, a, xd[i]});
            a = a + 10'd1;
        end
        done_q.push_back(t + 2 + n + RD_LAT);
        issue_cmd(1'b0, blk, addr, n);
        tick();
        cmd_valid = 1'b0;
        chk("busy_in_read", {31'd0, busy}, 32'd1);
        chk("cmd_ready_in_read", {31'd0, cmd_ready}, 32'd0);
        if (poke) begin
            tick();
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h200; cmd_len = 8'd0;
            wr_valid = 1'b1; wr_data = 32'h0000_BEEF;
            tick();
            cmd_valid = 1'b0; wr_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset with random inputs
        rst = 1'b1;
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_block = 1'($urandom);
        cmd_addr = 10'($urandom); cmd_len = 8'($urandom);
        wr_valid = 1'($urandom); wr_data = $urandom;
        tick();
        chk_reset("reset_cycle1");
        tick();
        chk_reset("reset_cycle2");
        rst = 1'b0;
        cmd_valid = 1'b0; wr_valid = 1'b0; cmd_write = 1'b0; cmd_block = 1'b0;
        cmd_addr = 10'h0; cmd_len = 8'd0; wr_data = 32'h0;
        mon_en = 1'b1;
        tick();

        // Write burst: block 1, 0x010, 4 words A0..A3 continuous
        do_write(1'b0, 10'h010, 4, 32'h0000_00A0, 16'hFFFF, 16);
        drain("write_cont");

        // Read with latency 2 across the address wrap, block 2
        xd[0] = 32'h2000_03FE; xd[1] = 32'h2000_03FF;
        xd[2] = 32'h2000_0000; xd[3] = 32'h2000_0001;
        do_read(1'b1, 10'h3FE, 4, 1'b0);
        drain("read_wrap");

        // Write with gaps: wr_valid 1,0,0,1,1 on a 3-word burst, block 2
        do_write(1'b1, 10'h3FF, 3, 32'h0000_00B0, 16'b0000_0000_0001_1001, 5);
        drain("write_gaps");

        // Read back the gapped write
        xd[0] = 32'h0000_00B0; xd[1] = 32'h0000_00B1; xd[2] = 32'h0000_00B2;
        do_read(1'b1, 10'h3FF, 3, 1'b0);
        drain("readback_gaps");

        // Block isolation: read block 1 while block 2 shows 0xDEAD; stray cmd/wr pokes
        force2 = 1'b1;
        xd[0] = 32'h0000_00A0; xd[1] = 32'h0000_00A1;
        xd[2] = 32'h0000_00A2; xd[3] = 32'h0000_00A3;
        do_read(1'b0, 10'h010, 4, 1'b1);
        drain("isolation");
        force2 = 1'b0;

        // Reset during the 3rd word of an 8-word read
        t = cyc;
        for (int i = 0; i < 3; i++) iss_q.push_back('{t + 1 + i, 2'b00, 10'h100 + 10'(i), 32'h0});
        issue_cmd(1'b0, 1'b0, 10'h100, 8);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("after_midburst_reset");
        for (int i = 0; i < 12; i++) tick();
        chk_reset("idle_after_reset");
        drain("midburst_reset");

        // Next command runs normally: single-word read of block 1 at 0x010
        xd[0] = 32'h0000_00A0;
        do_read(1'b0, 10'h010, 1, 1'b0);
        drain("post_reset_read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
